// File: rtl/iter_muldiv_unit.sv
// iter_muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, with divide-by-zero/overflow fast path and flush abort
module iter_muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [2:0]       func_i,
   input  logic [WIDTH-1:0] op_a_i,
   input  logic [WIDTH-1:0] op_b_i,
   output logic             ready_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             negative_o
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] count;
   logic [2:0] func_q;
   logic neg_q, fast_q;
   logic [WIDTH-1:0] hi, lo, opnd;
   logic accept, is_div, uns, sa, sb, div_zero, div_ovf, fast, neg;
   logic [WIDTH-1:0] ma, mb, fast_val, mag, mag_fix, fixed;
   logic [WIDTH:0] mul_sum, div_sh, div_diff;
   logic [2*WIDTH-1:0] prod, prod_fix;
   assign ready_o    = (state == IDLE) || (state == DONE);
   assign busy_o     = state == CALC;
   assign done_o     = state == DONE;
   assign zero_o     = result_o == '0;
   assign negative_o = result_o[WIDTH-1];
   always_comb begin
      accept   = start_i & ready_o & ~flush_i;
      is_div   = func_i[2];
      uns      = is_div ? func_i[0] : (func_i[1:0] == 2'd3);
      sa       = ~uns & op_a_i[WIDTH-1];
      sb       = ~uns & (func_i != 3'd2) & op_b_i[WIDTH-1];
      ma       = sa ? -op_a_i : op_a_i;
      mb       = sb ? -op_b_i : op_b_i;
      neg      = (is_div & func_i[1]) ? sa : (sa ^ sb);
      div_zero = is_div & (op_b_i == '0);
      div_ovf  = is_div & ~func_i[0] & (op_a_i == MIN) & (op_b_i == '1);
      fast     = div_zero | div_ovf;
      fast_val = div_zero ? (func_i[1] ? op_a_i : '1) : (func_i[1] ? '0 : op_a_i);
   end
   always_comb begin
      mul_sum  = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
      div_sh   = {hi, lo[WIDTH-1]};
      div_diff = div_sh - {1'b0, opnd};
      prod     = {hi, lo};
      prod_fix = neg_q ? -prod : prod;
      mag      = func_q[1] ? hi : lo;
      mag_fix  = neg_q ? -mag : mag;
      fixed    = func_q[2] ? mag_fix : (func_q[1:0] == 2'd0) ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH];
   end
   always_comb begin
      state_nxt = state;
      if (flush_i)
         state_nxt = IDLE;
      else if (state == CALC)
         state_nxt = (count == CW'(WIDTH)) ? DONE : CALC;
      else if (accept)
         state_nxt = CALC;
      else if (state == DONE)
         state_nxt = IDLE;
   end
   // Fast-path ops park in CALC with count preloaded to WIDTH so they finish on the next edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= '0;
         func_q   <= '0;
         neg_q    <= 1'b0;
         fast_q   <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         opnd     <= '0;
         result_o <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            func_q <= func_i;
            neg_q  <= neg;
            fast_q <= fast;
            hi     <= '0;
            lo     <= fast ? fast_val : (is_div ? ma : mb);
            opnd   <= is_div ? mb : ma;
            count  <= fast ? CW'(WIDTH) : '0;
         end else if (state == CALC && !flush_i) begin
            if (count != CW'(WIDTH)) begin
               count <= count + 1'b1;
               hi    <= func_q[2] ? (div_diff[WIDTH] ? div_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]) : mul_sum[WIDTH:1];
               lo    <= func_q[2] ? {lo[WIDTH-2:0], ~div_diff[WIDTH]} : {mul_sum[0], lo[WIDTH-1:1]};
            end else begin
               result_o <= fast_q ? lo : fixed;
            end
         end
      end
   end
endmodule
